// File: rtl/ls_exec_unit.sv
// rtl/ls_exec_unit.sv - load/store execution unit: address generation, data-memory req/ack, CDB completion
module ls_exec_unit #(
    parameter int DW   = 32,
    parameter int PRW  = 6,
    parameter int ROBW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue,
    input  logic [ROBW-1:0] rob_num_in,
    input  logic [PRW-1:0]  p_rd_in,
    input  logic [DW-1:0]   rs_data,
    input  logic [DW-1:0]   rt_data,
    input  logic [15:0]     immed,
    input  logic            mem_ren_in,
    input  logic            mem_wen_in,
    input  logic            recover,
    input  logic [ROBW-1:0] rob_num_rec,
    output logic [DW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic            mem_rd,
    output logic            mem_wr,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack,
    input  logic            cdb_grant,
    output logic            complete,
    output logic [PRW-1:0]  p_rd_compl,
    output logic            RegDest_compl,
    output logic [DW-1:0]   wb_data,
    output logic [ROBW-1:0] rob_num_compl,
    output logic            ls_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AGEN = 2'd1,
        MEM  = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_flush;

    logic [ROBW-1:0] r_rob;
    logic [PRW-1:0]  r_prd;
    logic [DW-1:0]   r_rs;
    logic [DW-1:0]   r_rt;
    logic [15:0]     r_imm;
    logic            r_isld;
    logic            r_isst;
    logic [DW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic            r_killed;

    assign w_accept = (r_state == IDLE) && issue && !recover && (mem_ren_in || mem_wen_in);
    assign w_flush  = recover && (r_rob == rob_num_rec) && (r_state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = AGEN;
            AGEN: w_state_nxt = w_flush ? IDLE : MEM;
            // An outstanding bus request is never abandoned; a kill only suppresses the broadcast.
            MEM:  if (mem_ack) w_state_nxt = (r_killed || w_flush) ? IDLE : WB;
            WB:   if (w_flush || cdb_grant) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rob    <= '0;
            r_prd    <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_imm    <= '0;
            r_isld   <= 1'b0;
            r_isst   <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_killed <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rob  <= rob_num_in;
                r_prd  <= p_rd_in;
                r_rs   <= rs_data;
                r_rt   <= rt_data;
                r_imm  <= immed;
                r_isld <= mem_ren_in;
                r_isst <= mem_wen_in;
            end
            if (r_state == AGEN) begin
                r_addr  <= r_rs + {{(DW-16){r_imm[15]}}, r_imm};
                r_wdata <= r_rt;
            end
            if ((r_state == MEM) && mem_ack && r_isld) begin
                r_rdata <= mem_rdata;
            end
            if (w_state_nxt == IDLE) begin
                r_killed <= 1'b0;
            end else if ((r_state == MEM) && w_flush) begin
                r_killed <= 1'b1;
            end
        end
    end

    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign mem_rd        = (r_state == MEM) && r_isld;
    assign mem_wr        = (r_state == MEM) && r_isst;
    assign complete      = (r_state == WB);
    assign p_rd_compl    = r_prd;
    assign RegDest_compl = r_isld;
    assign wb_data       = r_isld ? r_rdata : '0;
    assign rob_num_compl = r_rob;
    assign ls_busy       = (r_state != IDLE);

endmodule

// File: doc/ls_exec_unit.md
Name: ls_exec_unit

Overview:
- Consumer end of the load/store station issue interface.
- Accepts one in-order memory op per issue, computes the effective address, and runs a req/ack transaction on the data-memory port.
- Broadcasts completion on the CDB: p_rd_compl, RegDest_compl and complete, plus data and ROB number.
- Single op in flight; ls_busy drives the station's stall_hazard.

Parameters:
- DW, 32, data and address width.
- PRW, 6, physical register tag width.
- ROBW, 4, ROB index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- issue  in  1  station issued an op this cycle.
- rob_num_in  in  ROBW  ROB index of the issued op.
- p_rd_in  in  PRW  destination physical register (loads).
- rs_data  in  DW  base register value.
- rt_data  in  DW  store data value.
- immed  in  16  offset, sign-extended.
- mem_ren_in  in  1  op is a load.
- mem_wen_in  in  1  op is a store.
- recover  in  1  branch recovery pulse.
- rob_num_rec  in  ROBW  ROB index to flush.
- mem_addr  out  DW  data memory address.
- mem_wdata  out  DW  store data.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- mem_rdata  in  DW  read data, valid with mem_ack.
- mem_ack  in  1  transaction done.
- cdb_grant  in  1  CDB arbiter grants this unit.
- complete  out  1  CDB broadcast valid.
- p_rd_compl  out  PRW  destination tag broadcast.
- RegDest_compl  out  1  1 = load writes a register; 0 = store.
- wb_data  out  DW  load data (0 for stores).
- rob_num_compl  out  ROBW  ROB index completing.
- ls_busy  out  1  unit cannot accept an issue.

Behaviour:
- FSM states: IDLE, AGEN, MEM, WB.
  - ls_busy = (state != IDLE), combinational.
  - Reset: state IDLE; all registered fields, mem_rd, mem_wr and complete = 0; all outputs 0.
- IDLE: on issue && !recover && (mem_ren_in || mem_wen_in), latch rob_num, p_rd, rs, rt, immed, isLD, isST; go to AGEN.
  - issue with both enables 0, or issue while recover, is ignored.
  - issue while busy is a protocol error; ignore it and leave state unchanged.
- AGEN (1 cycle):
  - addr_q = rs + {{16{immed[15]}}, immed}, 32-bit wrap, no alignment check.
  - wdata_q = rt.
  - Go to MEM.
- MEM:
  - mem_rd = isLD, mem_wr = isST, mem_addr = addr_q, mem_wdata = wdata_q.
  - Requests are held stable until mem_ack.
  - On mem_ack: latch mem_rdata (loads); go to WB, or to IDLE if killed.
  - mem_ack may arrive in the first MEM cycle.
- WB:
  - complete = 1; p_rd_compl = p_rd_q; RegDest_compl = isLD; wb_data = isLD ? rdata_q : 0; rob_num_compl = rob_q.
  - Hold all of these until cdb_grant, then go to IDLE.
  - complete and cdb_grant in the same cycle = transfer.
- mem_addr/mem_wdata outside MEM hold their last value; mem_rd/mem_wr are 0 outside MEM.
- Latency, zero-wait memory and immediate grant:
  - issue at T; AGEN at T+1; mem_rd/mem_wr at T+2; complete at T+3; IDLE at T+4.
  - A new issue is accepted at T+4.
- Recovery: flush condition = recover && (rob_q == rob_num_rec) && state != IDLE.
  - In AGEN or WB: go to IDLE next cycle; complete is dropped even without a grant.
  - In MEM: the bus request is never cancelled.
    - Set the killed flag, keep mem_rd/mem_wr until mem_ack, then go to IDLE with no complete.
    - A flushed store's write still reaches memory; this is accepted behaviour.
  - killed is cleared on entering IDLE.
  - recover with a non-matching ROB index has no effect.
- Simultaneous mem_ack and matching recover in MEM: treat as killed, go to IDLE, no complete.
- Reset mid-operation: immediate return to IDLE; mem_rd, mem_wr and complete go to 0 asynchronously.

Test Plan:
- Load: rs=0x1000, immed=0xFFFC, p_rd=0x12, rob=3; mem_ack in first MEM cycle with rdata=0xDEADBEEF; grant immediate -> mem_rd at T+2 with mem_addr=0x0FFC; complete at T+3 with p_rd_compl=0x12, RegDest_compl=1, wb_data=0xDEADBEEF, rob_num_compl=3; ls_busy low at T+4.
- Store: rs=0x20, immed=0x8, rt=0x55; mem_ack after 3 wait cycles -> mem_wr high for 4 cycles with addr 0x28 and wdata 0x55; then complete with RegDest_compl=0 and wb_data=0.
- Grant stall: load completes but cdb_grant is withheld for 5 cycles -> complete and all CDB fields stable for 6 cycles; issue pulses during the stall are ignored.
- Flush in AGEN: rob=7, recover with rob_num_rec=7 at T+1 -> no mem_rd, no complete, IDLE at T+2. With rob_num_rec=6 -> normal completion.
- Flush in MEM: load rob=2, recover with rob_num_rec=2 during a wait state -> mem_rd held until ack, then IDLE with no complete.
- Async reset asserted mid-MEM -> mem_rd=0, complete=0, ls_busy=0 immediately; a fresh load after reset completes normally.
